// File: rtl/handshake_fifo_pkg.sv
// Shared defaults for the handshake FIFO slice.
package handshake_fifo_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 4;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping index counter for FIFO read/write pointers; wraps DEPTH-1 -> 0 by compare.
module fifo_ptr #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/handshake_fifo.sv
// Elastic handshake buffer of DEPTH beats; in_ready depends only on stored state and rst.
module handshake_fifo
  import handshake_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]    level_d, level_q;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full_st, empty_st;
  logic             push, pop;

  assign full_st  = (level_q == LW'(DEPTH));
  assign empty_st = (level_q == '0);

  assign in_ready  = !full_st && !rst;
  assign out_valid = !empty_st && !rst;
  assign full      = full_st && !rst;
  assign empty     = empty_st || rst;
  assign level     = rst ? '0 : level_q;
  assign out_data  = rst ? '0 : mem_q[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Flush wins over any same-cycle transfer: nothing is written and no pointer moves.
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) begin
      mem_d[wr_ptr] = in_data;
    end
  end

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      mem_q   <= mem_d;
    end
  end

  fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push && !flush),
    .ptr (wr_ptr)
  );

  fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop && !flush),
    .ptr (rd_ptr)
  );

endmodule
